// File: rtl/ysyx_22041461_mem_arb.sv
// ---------------------------------------------------------------------------
// ysyx_22041461_mem_arb
// Two-master / one-slave memory arbiter. It shares the single memory port
// between instruction fetch (IF) and load/store (LS). Only one transaction is
// outstanding at a time. A three-state FSM sequences each transaction:
//   IDLE  : pick a winner and latch its request fields
//   ISSUE : hold mem_req_valid until the memory accepts the request
//   WAIT  : wait for mem_resp_valid, then route the response to the owner
//
// Configuration macro: YSYX_22041461_MEM_ARB_RR_EN
//   defined   -> round-robin on conflict. The master not granted last wins.
//                last_grant resets to IF, so the first conflict goes to LS.
//   undefined -> fixed priority. LS wins every conflict.
//
// Ports
//   clk, rst              clock; synchronous active-low reset
//   if_req_*  / if_addr   fetch request channel (ready only in IDLE)
//   if_resp_* / if_rdata  fetch response, one-cycle pulse
//   ls_req_*  / ls_addr, ls_wen, ls_wdata, ls_wmask   load/store request
//   ls_resp_* / ls_rdata  load data or store acknowledge, one-cycle pulse
//   mem_req_* / mem_addr, mem_wen, mem_wdata, mem_wmask   latched request
//   mem_resp_valid, mem_rdata                             memory response
//   busy                  FSM is not in IDLE
// ---------------------------------------------------------------------------
module ysyx_22041461_mem_arb #(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  if_req_valid,
  output logic                  if_req_ready,
  input  logic [ADDR_W-1:0]     if_addr,
  output logic                  if_resp_valid,
  output logic [DATA_W-1:0]     if_rdata,
  input  logic                  ls_req_valid,
  output logic                  ls_req_ready,
  input  logic [ADDR_W-1:0]     ls_addr,
  input  logic                  ls_wen,
  input  logic [DATA_W-1:0]     ls_wdata,
  input  logic [DATA_W/8-1:0]   ls_wmask,
  output logic                  ls_resp_valid,
  output logic [DATA_W-1:0]     ls_rdata,
  output logic                  mem_req_valid,
  input  logic                  mem_req_ready,
  output logic [ADDR_W-1:0]     mem_addr,
  output logic                  mem_wen,
  output logic [DATA_W-1:0]     mem_wdata,
  output logic [DATA_W/8-1:0]   mem_wmask,
  input  logic                  mem_resp_valid,
  input  logic [DATA_W-1:0]     mem_rdata,
  output logic                  busy
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;

  localparam logic OWN_IF = 1'b0;
  localparam logic OWN_LS = 1'b1;

  logic [1:0]          state_r;
  logic [1:0]          state_nxt_s;
  logic                owner_r;
  logic [ADDR_W-1:0]   addr_r;
  logic                wen_r;
  logic [DATA_W-1:0]   wdata_r;
  logic [DATA_W/8-1:0] wmask_r;

  logic in_idle_s;
  logic conflict_to_ls_s;
  logic grant_if_s;
  logic grant_ls_s;
  logic accept_s;
  logic resp_hit_s;

  assign in_idle_s = (state_r == ST_IDLE);

`ifdef YSYX_22041461_MEM_ARB_RR_EN
  logic last_grant_r;

  // On conflict, LS wins only if IF was the last master granted
  assign conflict_to_ls_s = (last_grant_r == OWN_IF);

  // Remember which master was granted most recently
  always_ff @(posedge clk) begin
    if (!rst) begin
      last_grant_r <= OWN_IF;
    end else if (accept_s) begin
      last_grant_r <= grant_ls_s ? OWN_LS : OWN_IF;
    end
  end
`else
  assign conflict_to_ls_s = 1'b1;
`endif

  // Winner selection. Grants are held off while reset is asserted so that
  // no ready pulse leaks out during reset.
  always_comb begin
    grant_if_s = 1'b0;
    grant_ls_s = 1'b0;
    if (rst && in_idle_s) begin
      if (ls_req_valid && (!if_req_valid || conflict_to_ls_s)) begin
        grant_ls_s = 1'b1;
      end else if (if_req_valid) begin
        grant_if_s = 1'b1;
      end else begin
        grant_if_s = 1'b0;
        grant_ls_s = 1'b0;
      end
    end else begin
      grant_if_s = 1'b0;
      grant_ls_s = 1'b0;
    end
  end

  assign accept_s     = grant_if_s | grant_ls_s;
  assign if_req_ready = grant_if_s;
  assign ls_req_ready = grant_ls_s;

  // Next-state logic for the accept / issue / response sequence
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) begin
          state_nxt_s = ST_ISSUE;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        if (mem_req_ready) begin
          state_nxt_s = ST_WAIT;
        end else begin
          state_nxt_s = ST_ISSUE;
        end
      end
      ST_WAIT: begin
        if (mem_resp_valid) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_WAIT;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // State register plus latched request fields. The fields stay frozen from
  // accept until the next accept, so the memory sees a stable request.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r <= ST_IDLE;
      owner_r <= OWN_IF;
      addr_r  <= {ADDR_W{1'b0}};
      wen_r   <= 1'b0;
      wdata_r <= {DATA_W{1'b0}};
      wmask_r <= {(DATA_W/8){1'b0}};
    end else begin
      state_r <= state_nxt_s;
      if (accept_s) begin
        owner_r <= grant_ls_s ? OWN_LS : OWN_IF;
        addr_r  <= grant_ls_s ? ls_addr : if_addr;
        wen_r   <= grant_ls_s ? ls_wen : 1'b0;
        wdata_r <= grant_ls_s ? ls_wdata : {DATA_W{1'b0}};
        wmask_r <= grant_ls_s ? ls_wmask : {(DATA_W/8){1'b0}};
      end
    end
  end

  // A response is only meaningful in WAIT. Anything seen earlier is dropped.
  assign resp_hit_s = rst && (state_r == ST_WAIT) && mem_resp_valid;

  // Steer the response to the owner. The data bus is zeroed when idle.
  always_comb begin
    if_resp_valid = 1'b0;
    ls_resp_valid = 1'b0;
    if_rdata      = {DATA_W{1'b0}};
    ls_rdata      = {DATA_W{1'b0}};
    if (resp_hit_s) begin
      if (owner_r == OWN_LS) begin
        ls_resp_valid = 1'b1;
        ls_rdata      = mem_rdata;
      end else begin
        if_resp_valid = 1'b1;
        if_rdata      = mem_rdata;
      end
    end else begin
      if_resp_valid = 1'b0;
      ls_resp_valid = 1'b0;
    end
  end

  assign mem_req_valid = rst && (state_r == ST_ISSUE);
  assign busy          = rst && (state_r != ST_IDLE);
  assign mem_addr      = addr_r;
  assign mem_wen       = wen_r;
  assign mem_wdata     = wdata_r;
  assign mem_wmask     = wmask_r;

endmodule

// File: tb/tb_ysyx_22041461_mem_arb.sv
// ---------------------------------------------------------------------------
// Self-checking bench for ysyx_22041461_mem_arb. A directed sequence drives
// both masters and plays the memory side. Expected responses are queued when
// a request is accepted. A negedge monitor pops and compares them whenever
// the DUT pulses a response.
// ---------------------------------------------------------------------------
module tb_ysyx_22041461_mem_arb;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req_valid, if_req_ready, if_resp_valid;
  logic [63:0] if_addr, if_rdata;
  logic        ls_req_valid, ls_req_ready, ls_wen, ls_resp_valid;
  logic [63:0] ls_addr, ls_wdata, ls_rdata;
  logic [7:0]  ls_wmask;
  logic        mem_req_valid, mem_req_ready, mem_wen, mem_resp_valid;
  logic [63:0] mem_addr, mem_wdata, mem_rdata;
  logic [7:0]  mem_wmask;
  logic        busy;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic        owner;     // 1 = LS, 0 = IF
    logic        chk_data;  // 0 for store acknowledges
    logic [63:0] rdata;
  } exp_t;
  exp_t exp_q[$];

  ysyx_22041461_mem_arb dut (
    .clk(clk), .rst(rst),
    .if_req_valid(if_req_valid), .if_req_ready(if_req_ready), .if_addr(if_addr),
    .if_resp_valid(if_resp_valid), .if_rdata(if_rdata),
    .ls_req_valid(ls_req_valid), .ls_req_ready(ls_req_ready), .ls_addr(ls_addr),
    .ls_wen(ls_wen), .ls_wdata(ls_wdata), .ls_wmask(ls_wmask),
    .ls_resp_valid(ls_resp_valid), .ls_rdata(ls_rdata),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_addr(mem_addr), .mem_wen(mem_wen), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
    .mem_resp_valid(mem_resp_valid), .mem_rdata(mem_rdata), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic owner, input logic chk_data, input logic [63:0] rdata);
    exp_t e;
    e.owner = owner;
    e.chk_data = chk_data;
    e.rdata = rdata;
    exp_q.push_back(e);
  endtask

  // Scoreboard: every response pulse must match the oldest queued expectation
  always @(negedge clk) begin
    if (rst === 1'b1 && (if_resp_valid === 1'b1 || ls_resp_valid === 1'b1)) begin
      chk("resp_onehot", {63'd0, if_resp_valid & ls_resp_valid}, 64'd0);
      if (exp_q.size() == 0) begin
        chk("resp_unexpected", 64'd1, 64'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("resp_owner", {63'd0, ls_resp_valid}, {63'd0, e.owner});
        if (e.chk_data) begin
          chk("resp_rdata", e.owner ? ls_rdata : if_rdata, e.rdata);
        end
      end
    end
  end

  // Expected grant sequence with both masters held valid
  logic exp_ls_grant [4];

  initial begin
`ifdef YSYX_22041461_MEM_ARB_RR_EN
    exp_ls_grant = '{1'b1, 1'b0, 1'b1, 1'b0};
`else
    exp_ls_grant = '{1'b1, 1'b1, 1'b1, 1'b1};
`endif
    rst = 1'b0;
    if_req_valid = 1'b1; if_addr = 64'h0;
    ls_req_valid = 1'b1; ls_addr = 64'h0; ls_wen = 1'b0; ls_wdata = 64'h0; ls_wmask = 8'h0;
    mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_rdata = 64'h0;

    // Reset: requests present but nothing is granted
    cyc(); cyc();
    chk("rst_if_ready", {63'd0, if_req_ready}, 64'd0);
    chk("rst_ls_ready", {63'd0, ls_req_ready}, 64'd0);
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_mem_valid", {63'd0, mem_req_valid}, 64'd0);
    chk("rst_mem_addr", mem_addr, 64'd0);
    chk("rst_mem_wen", {63'd0, mem_wen}, 64'd0);
    if_req_valid = 1'b0; ls_req_valid = 1'b0;

    cyc(); rst = 1'b1;
    #1 chk("idle_busy", {63'd0, busy}, 64'd0);

    // Single IF fetch
    cyc(); if_req_valid = 1'b1; if_addr = 64'h8000_0000;
    #1 chk("t1_if_ready", {63'd0, if_req_ready}, 64'd1);
    chk("t1_ls_ready", {63'd0, ls_req_ready}, 64'd0);
    push(1'b0, 1'b1, 64'h13);
    cyc(); if_req_valid = 1'b0; mem_req_ready = 1'b1;
    #1 chk("t1_mem_valid", {63'd0, mem_req_valid}, 64'd1);
    chk("t1_mem_addr", mem_addr, 64'h8000_0000);
    chk("t1_mem_wen", {63'd0, mem_wen}, 64'd0);
    chk("t1_busy", {63'd0, busy}, 64'd1);
    cyc(); mem_req_ready = 1'b0; mem_resp_valid = 1'b1; mem_rdata = 64'h13;
    #1 chk("t1_if_resp", {63'd0, if_resp_valid}, 64'd1);
    chk("t1_ls_resp", {63'd0, ls_resp_valid}, 64'd0);
    cyc(); mem_resp_valid = 1'b0;
    #1 chk("t1_busy_end", {63'd0, busy}, 64'd0);

    // Conflict: IF fetch against LS store, LS must win first
    if_req_valid = 1'b1; if_addr = 64'h8000_0004;
    ls_req_valid = 1'b1; ls_addr = 64'h8000_1000; ls_wen = 1'b1;
    ls_wdata = 64'hDEAD_BEEF; ls_wmask = 8'h0F;
    #1 chk("t2_ls_ready", {63'd0, ls_req_ready}, 64'd1);
    chk("t2_if_ready", {63'd0, if_req_ready}, 64'd0);
    push(1'b1, 1'b0, 64'h0);
    cyc(); mem_req_ready = 1'b1;
`ifdef YSYX_22041461_MEM_ARB_RR_EN
    ls_req_valid = 1'b1;
`else
    ls_req_valid = 1'b0;
`endif
    #1 chk("t2_mem_wen", {63'd0, mem_wen}, 64'd1);
    chk("t2_mem_wmask", {56'd0, mem_wmask}, 64'h0F);
    chk("t2_mem_addr", mem_addr, 64'h8000_1000);
    chk("t2_mem_wdata", mem_wdata, 64'hDEAD_BEEF);
    cyc(); mem_req_ready = 1'b0; mem_resp_valid = 1'b1; mem_rdata = 64'h55;
    #1 chk("t2_ls_resp", {63'd0, ls_resp_valid}, 64'd1);
    cyc(); mem_resp_valid = 1'b0;
    #1 chk("t2_if_ready_next", {63'd0, if_req_ready}, 64'd1);
    chk("t2_ls_ready_next", {63'd0, ls_req_ready}, 64'd0);
    push(1'b0, 1'b1, 64'h77);

    // Stall in ISSUE for 5 cycles; both masters keep requesting and a
    // spurious response shows up mid-stall
    for (int k = 0; k < 5; k++) begin
      cyc(); if_req_valid = 1'b1; ls_req_valid = 1'b1; ls_wen = 1'b0;
      mem_req_ready = 1'b0; mem_resp_valid = (k == 2);
      #1 chk("stall_mem_valid", {63'd0, mem_req_valid}, 64'd1);
      chk("stall_mem_addr", mem_addr, 64'h8000_0004);
      chk("stall_fields", {mem_wdata[55:0], mem_wmask}, 64'd0);
      chk("stall_readies", {62'd0, if_req_ready, ls_req_ready}, 64'd0);
    end
    cyc(); if_req_valid = 1'b0; ls_req_valid = 1'b0;
    mem_resp_valid = 1'b0; mem_req_ready = 1'b1;
    #1 chk("stall_release", {63'd0, mem_req_valid}, 64'd1);
    cyc(); mem_req_ready = 1'b0; mem_resp_valid = 1'b1; mem_rdata = 64'h77;
    #1 chk("stall_if_resp", {63'd0, if_resp_valid}, 64'd1);
    cyc(); mem_resp_valid = 1'b1; mem_rdata = 64'h99;
    #1 chk("spur_idle_busy", {63'd0, busy}, 64'd0);
    cyc(); mem_resp_valid = 1'b0;
    #1 chk("spur_idle_busy2", {63'd0, busy}, 64'd0);

    // Both masters held valid for four loads
    if_req_valid = 1'b1; if_addr = 64'h8000_0100;
    ls_req_valid = 1'b1; ls_addr = 64'h8000_2200; ls_wen = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1 chk("rr_ls_ready", {63'd0, ls_req_ready}, {63'd0, exp_ls_grant[i]});
      chk("rr_if_ready", {63'd0, if_req_ready}, {63'd0, ~exp_ls_grant[i]});
      push(exp_ls_grant[i], 1'b1, 64'h100 + 64'(i));
      cyc(); mem_req_ready = 1'b1;
      #1 chk("rr_mem_addr", mem_addr, exp_ls_grant[i] ? 64'h8000_2200 : 64'h8000_0100);
      cyc(); mem_req_ready = 1'b0; mem_resp_valid = 1'b1; mem_rdata = 64'h100 + 64'(i);
      cyc(); mem_resp_valid = 1'b0;
      if_req_valid = (i < 3); ls_req_valid = (i < 3);
    end

    // Reset while in WAIT abandons the load silently
    cyc(); ls_req_valid = 1'b1; ls_addr = 64'h8000_2000; ls_wen = 1'b0;
    #1 chk("rw_ls_ready", {63'd0, ls_req_ready}, 64'd1);
    cyc(); ls_req_valid = 1'b0; mem_req_ready = 1'b1;
    cyc(); mem_req_ready = 1'b0;
    #1 chk("rw_in_wait", {63'd0, busy}, 64'd1);
    rst = 1'b0;
    cyc(); rst = 1'b1; mem_resp_valid = 1'b1; mem_rdata = 64'hBAD;
    #1 chk("rw_busy", {63'd0, busy}, 64'd0);
    chk("rw_ls_resp", {63'd0, ls_resp_valid}, 64'd0);
    chk("rw_mem_valid", {63'd0, mem_req_valid}, 64'd0);
    chk("rw_mem_fields", mem_addr | mem_wdata | {56'd0, mem_wmask} | {63'd0, mem_wen}, 64'd0);
    cyc(); mem_resp_valid = 1'b0; ls_req_valid = 1'b1;
    #1 chk("rw_reissue_ready", {63'd0, ls_req_ready}, 64'd1);
    push(1'b1, 1'b1, 64'hCAFE);
    cyc(); ls_req_valid = 1'b0; mem_req_ready = 1'b1;
    #1 chk("rw_mem_addr", mem_addr, 64'h8000_2000);
    cyc(); mem_req_ready = 1'b0; mem_resp_valid = 1'b1; mem_rdata = 64'hCAFE;
    #1 chk("rw_ls_resp2", {63'd0, ls_resp_valid}, 64'd1);
    cyc(); mem_resp_valid = 1'b0;
    #1 chk("rw_busy_end", {63'd0, busy}, 64'd0);

    cyc();
    chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
